encoder_4to2_reg: RTL
=====================

// Module: encoder_4to2_reg
//
// PURPOSE
//   Registered 4-to-2-line encoder: the return path for the 2-to-4 decoder.
//   Takes decoded one-hot lines y (active-high or active-low per active_low)
//   and recovers the 2-bit code a. Flags zero-hot and multi-hot inputs.
//   Handshaked on both sides with a 2-entry skid buffer; counts bad words.
//
// PARAMETERS
//   ERR_CNT_W     8  width of the saturating error counter err_count
//   MSB_PRIORITY  1  1: highest asserted line wins on multi-hot; 0: lowest wins
//
// PORTS
//   clock      in   1          rising-edge clock
//   reset_n    in   1          asynchronous, active-low reset
//   in_valid   in   1          y/active_low valid this cycle
//   in_ready   out  1          block can accept; transfer = in_valid & in_ready
//   y          in   4          decoded lines, y[3]..y[0]
//   active_low in   1          1: y lines are active-low; sampled with y
//   out_valid  out  1          a/multi/none hold a word
//   out_ready  in   1          consumer takes word; transfer = out_valid & out_ready
//   a          out  2          encoded index
//   multi      out  1          >1 line asserted in this word
//   none       out  1          no line asserted in this word (a = 2'b00)
//   clear_err  in   1          synchronous clear of err_count
//   err_count  out  ERR_CNT_W  number of accepted words with multi|none
//
// BEHAVIOUR
//   Normalise: yn = active_low ? ~y : y. Then, per MSB_PRIORITY:
//     - a = index of the winning set bit of yn.
//     - multi = (popcount(yn) > 1).
//     - none = (yn == 4'b0000), with a = 2'b00.
//   Reset (reset_n low, async): out_valid=0, a=00, multi=0, none=0, in_ready=1,
//     err_count=0, skid emptied. In-flight words are discarded, not delivered.
//   States: EMPTY (no word), ONE (output reg full), TWO (output + skid full).
//     EMPTY: in xfer -> ONE.
//     ONE:   in xfer & !out xfer -> TWO.
//            out xfer & !in xfer -> EMPTY.
//            both -> ONE (new word loaded).
//     TWO:   out xfer -> ONE (skid moves to output reg); no input accepted.
//   in_ready = (state != TWO); registered-only, no comb path from out_ready.
//   Latency: word accepted at edge N appears on a/multi/none with out_valid=1
//     after edge N. Throughput 1 word/clock when out_ready held high.
//   While out_valid=1 and out_ready=0: a, multi and none hold stable.
//   Order preserved; no word is dropped or duplicated.
//   err_count: +1 at each accepted word with multi|none. Saturates at all-ones.
//     Counted at input acceptance, not delivery.
//   clear_err: sets err_count to 0 next edge. Wins over a coincident increment,
//     so that error is not counted.
//   active_low is per-word; changing it between words is legal.
//
// TESTING
//   1. active_low=0, out_ready=1, y=0001,0010,0100,1000 back-to-back
//      -> a=00,01,10,11 one clock later each; multi=0, none=0, err_count=0.
//   2. active_low=1, y=1110,1101,1011,0111 -> a=00,01,10,11.
//      Loop decoder->encoder over all 8 (a, active_low) combos -> a returned unchanged.
//   3. out_ready=0, offer y=0001,0010,0100 -> first two accepted, then in_ready=0,
//      a holds 00. Raise out_ready -> a=00,01,10 in order, in_ready back to 1.
//   4. MSB_PRIORITY=1: y=0110 -> a=10, multi=1. y=0000 -> a=00, none=1;
//      err_count=2. ERR_CNT_W=2, 5 bad words -> err_count=3 (saturated).
//      clear_err with a bad word -> err_count=0.
//   5. In TWO state, drop reset_n between edges -> out_valid=0, in_ready=1,
//      err_count=0 immediately. After release, no stale word is emitted.

Source files
------------

// File: rtl/encoder_4to2_reg.sv
// Registered 4-to-2 encoder with valid/ready handshakes on both sides.
// It turns decoded one-hot lines (active-high or active-low) back into a
// 2-bit index and flags words with no line or several lines asserted.
// A 2-entry skid buffer (output register plus one skid register) lets
// in_ready depend only on local state, never on out_ready. A saturating
// counter records accepted bad words.
module encoder_4to2_reg #(
    parameter int ERR_CNT_W    = 8,
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           y,
    input  logic                 active_low,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           a,
    output logic                 multi,
    output logic                 none,
    input  logic                 clear_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Buffer occupancy: no word, output register full, output + skid full.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [1:0]           a_reg, skid_a_reg;
    logic                 multi_reg, skid_multi_reg;
    logic                 none_reg, skid_none_reg;
    logic [ERR_CNT_W-1:0] err_count_reg;

    logic [3:0] yn;
    logic [1:0] enc_a;
    logic       enc_multi;
    logic       enc_none;
    logic [2:0] pop;
    logic       in_xfer;
    logic       out_xfer;

    // Handshake flags; both come from registered state only.
    assign in_ready  = (state_reg != ST_TWO);
    assign out_valid = (state_reg != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    assign a         = a_reg;
    assign multi     = multi_reg;
    assign none      = none_reg;
    assign err_count = err_count_reg;

    // Normalise polarity, then pick the winning line and count set lines.
    // Scanning so that the preferred end is visited last makes it win.
    always_comb begin
        yn    = active_low ? ~y : y;
        pop   = {2'b00, yn[0]} + {2'b00, yn[1]} + {2'b00, yn[2]} + {2'b00, yn[3]};
        enc_a = 2'b00;
        if (MSB_PRIORITY) begin
            for (int i = 0; i < 4; i++) begin
                if (yn[i]) enc_a = i[1:0];
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (yn[i]) enc_a = i[1:0];
            end
        end
        enc_multi = (pop > 3'd1);
        enc_none  = (pop == 3'd0);
    end

    // Next occupancy from the two transfer strobes.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (in_xfer) state_next = ST_ONE;
            ST_ONE: begin
                if (in_xfer && !out_xfer)      state_next = ST_TWO;
                else if (out_xfer && !in_xfer) state_next = ST_EMPTY;
            end
            ST_TWO:   if (out_xfer) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Occupancy state plus output/skid word registers. A new word goes to the
    // output register when it is (or is becoming) free, otherwise to the skid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_EMPTY;
            a_reg          <= 2'b00;
            multi_reg      <= 1'b0;
            none_reg       <= 1'b0;
            skid_a_reg     <= 2'b00;
            skid_multi_reg <= 1'b0;
            skid_none_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        a_reg     <= enc_a;
                        multi_reg <= enc_multi;
                        none_reg  <= enc_none;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        a_reg     <= enc_a;
                        multi_reg <= enc_multi;
                        none_reg  <= enc_none;
                    end else if (in_xfer) begin
                        skid_a_reg     <= enc_a;
                        skid_multi_reg <= enc_multi;
                        skid_none_reg  <= enc_none;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        a_reg     <= skid_a_reg;
                        multi_reg <= skid_multi_reg;
                        none_reg  <= skid_none_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating bad-word counter, counted at acceptance; clear wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count_reg <= '0;
        end else if (clear_err) begin
            err_count_reg <= '0;
        end else if (in_xfer && (enc_multi || enc_none) && !(&err_count_reg)) begin
            err_count_reg <= err_count_reg + ERR_CNT_W'(1);
        end
    end

endmodule
